io_periph: RTL and testbench
============================

IO_PERIPH -- requirements
Module: io_periph

Interface
REQ-001 Parameter CLKS_PER_BIT, default 217, sets clock cycles per UART bit; legal range is 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 16, sets TX FIFO entries; it SHALL be a power of two, minimum 2.
REQ-003 Port clk_i, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset_i, input, 1 bit, is the reset; it SHALL be asynchronous and active-low.
REQ-005 Port IO_memAddr_i, input, 32 bits, is the processor IO byte address; only bits [5:2] SHALL be decoded.
REQ-006 Port IO_memWData_i, input, 32 bits, is the processor IO write data.
REQ-007 Port IO_memWr_i, input, 1 bit, is a single-cycle write strobe.
REQ-008 Port IO_memRData_o, output, 32 bits, is the read data for the addressed register.
REQ-009 Port leds_o, output, 8 bits, drives the LED register.
REQ-010 Port uart_tx_o, output, 1 bit, is the UART serial line; it idles high.

Function
REQ-011 The register map SHALL be, by word offset: 0 LEDS (RW, bits [7:0]); 1 UART_DATA (WO, bits [7:0]); 2 UART_STATUS (R, W1C); 3 CYCLE (RW, 32 bits).
REQ-012 IO_memRData_o SHALL be combinational from the current address and current register state, in the same cycle, with no read side effects.
REQ-013 Offsets 4..15 SHALL read 0; writes to them SHALL be ignored; UART_DATA SHALL read 0.
REQ-014 A write SHALL take effect at the clock edge ending the strobe cycle; a read in that same cycle SHALL return the old value.
REQ-015 UART_STATUS fields: bit0 busy (FSM not IDLE); bit1 full; bit2 empty; bit3 overflow (sticky); bits [12:8] count, saturating at FIFO_DEPTH; all other bits read 0.
REQ-016 Writing UART_STATUS with bit3=1 SHALL clear overflow; other bits of that write SHALL be ignored.
REQ-017 A write to UART_DATA SHALL push WData[7:0] when the FIFO is not full, or when a pop occurs in the same cycle.
REQ-018 Otherwise the push SHALL be dropped and overflow SHALL be set; if a clear and a set of overflow coincide, the set SHALL win.
REQ-019 CYCLE SHALL increment by 1 every cycle and wrap from 0xFFFFFFFF to 0; a write SHALL load WData, and the load SHALL win over the increment.
REQ-020 The TX FSM SHALL have four states: IDLE, START, DATA, STOP. The line is 8N1, LSB first.
REQ-021 IDLE->START SHALL occur when the FIFO is non-empty; the head SHALL be popped on that edge, and uart_tx_o SHALL go low in the next cycle.
REQ-022 Each START, DATA and STOP bit SHALL be held for exactly CLKS_PER_BIT cycles, using a baud counter reloaded on each bit.
REQ-023 START->DATA SHALL occur after 1 bit time; DATA SHALL advance after 8 bits; STOP SHALL be driven high for 1 bit time.
REQ-024 At the end of STOP, the FSM SHALL pop and go to START if the FIFO is non-empty, else go to IDLE. Back-to-back frames SHALL therefore take exactly 10*CLKS_PER_BIT cycles each.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full and empty SHALL be derived from count, not from pointer equality alone.

Reset
REQ-026 While reset_i=0, the following SHALL hold: leds_o=0, CYCLE=0, overflow=0, FIFO empty, pointers=0, FSM=IDLE, baud counter=0, uart_tx_o=1.
REQ-027 Reset asserted mid-frame SHALL immediately force uart_tx_o=1 and discard both the FIFO contents and the frame in progress.
REQ-028 The first CYCLE increment SHALL occur on the first rising edge after reset_i deasserts.

Structure
REQ-029 A shared package io_periph_pkg SHALL hold:
- the register offset constants;
- the status bit positions;
- the TX state enumeration.
REQ-030 The FSM, baud counter and shift register SHALL form the sub-module io_uart_tx. It SHALL have a valid/ready pop handshake with the FIFO, which stays in io_periph.
REQ-031 The total RTL SHALL be 120-400 lines and SHALL NOT instantiate vendor primitives.

Verification
REQ-032 With CLKS_PER_BIT=4, write UART_DATA=0xA5:
- uart_tx_o low for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles;
- busy=1 throughout, then 0.
REQ-033 With CLKS_PER_BIT=4 and FIFO_DEPTH=4, write 6 bytes on consecutive cycles:
- the first pop frees one slot, so 5 are accepted and 1 is dropped;
- overflow=1;
- 5 frames follow, 40 cycles apart, with no idle gap;
- then write STATUS=0x8, and overflow reads 0.
REQ-034 Write LEDS=0x1FF: leds_o=0xFF, and reading offset 0 returns 0x000000FF.
REQ-035 Write CYCLE=0xFFFFFFFE: reads in the following cycles return 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
REQ-036 Assert reset_i=0 during DATA bit 3 of a frame:
- uart_tx_o=1 at once, STATUS reads 0x00000004 after reset, and no frame resumes.
REQ-037 Read offset 9 while UART_DATA pushes occur: returns 0, and FIFO count is unaffected by reads.

Source files
------------

// File: rtl/io_periph_pkg.sv
// Shared definitions for the IO peripheral block: register map, status layout
// and UART transmitter states.
package io_periph_pkg;

    localparam logic [3:0] OFF_LEDS        = 4'd0;
    localparam logic [3:0] OFF_UART_DATA   = 4'd1;
    localparam logic [3:0] OFF_UART_STATUS = 4'd2;
    localparam logic [3:0] OFF_CYCLE       = 4'd3;

    localparam int ST_BUSY      = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_EMPTY     = 2;
    localparam int ST_OVERFLOW  = 3;
    localparam int ST_COUNT_LSB = 8;
    localparam int ST_COUNT_W   = 5;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_e;

endpackage

// File: rtl/io_uart_tx.sv
// 8N1 UART transmitter. Pulls bytes from an external FIFO through a
// valid/ready handshake; the line idles high.
module io_uart_tx
    import io_periph_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       data_valid_i,
    input  logic [7:0] data_i,
    output logic       data_ready_o,
    output logic       tx_o,
    output logic       busy_o
);
    localparam int              CNT_W       = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             bit_done;
    logic             pop;

    assign bit_done = (baud_q == '0);
    // Ready in IDLE or on the last STOP cycle, so back-to-back frames have no gap.
    assign data_ready_o = (state_q == TX_IDLE) || ((state_q == TX_STOP) && bit_done);
    assign pop = data_valid_i && data_ready_o;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q   <= TX_IDLE;
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        case (state_q)
            TX_IDLE: begin
                if (pop) begin
                    state_d = TX_START;
                    baud_d  = BAUD_RELOAD;
                    shift_d = data_i;
                end
            end
            TX_START: begin
                if (bit_done) begin
                    state_d   = TX_DATA;
                    baud_d    = BAUD_RELOAD;
                    bit_idx_d = 3'd0;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            TX_DATA: begin
                if (bit_done) begin
                    baud_d  = BAUD_RELOAD;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = TX_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            TX_STOP: begin
                if (bit_done) begin
                    if (pop) begin
                        state_d = TX_START;
                        baud_d  = BAUD_RELOAD;
                        shift_d = data_i;
                    end else begin
                        state_d = TX_IDLE;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
            default: state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_o   = 1'b1;
        busy_o = (state_q != TX_IDLE);
        case (state_q)
            TX_START: tx_o = 1'b0;
            TX_DATA:  tx_o = shift_q[0];
            default:  tx_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/io_periph.sv
// Memory-mapped IO block: LED register, free-running cycle counter and a
// FIFO-buffered UART transmitter.
module io_periph
    import io_periph_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] IO_memAddr_i,
    input  logic [31:0] IO_memWData_i,
    input  logic        IO_memWr_i,
    output logic [31:0] IO_memRData_o,
    output logic [7:0]  leds_o,
    output logic        uart_tx_o
);
    localparam int               PTR_W = $clog2(FIFO_DEPTH);
    localparam int               CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(FIFO_DEPTH);

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [7:0]       leds_q, leds_d;
    logic [31:0]      cycle_q, cycle_d;
    logic             ovf_q, ovf_d;

    logic [3:0]  word;
    logic        wr_leds, wr_data, wr_status, wr_cycle;
    logic        full, empty, push, pop, tx_ready, tx_busy;
    logic [31:0] count_ext;
    logic [4:0]  count_field;
    logic [31:0] status;
    logic        unused_addr_bits;

    assign word             = IO_memAddr_i[5:2];
    assign unused_addr_bits = ^{IO_memAddr_i[31:6], IO_memAddr_i[1:0]};
    assign wr_leds   = IO_memWr_i && (word == OFF_LEDS);
    assign wr_data   = IO_memWr_i && (word == OFF_UART_DATA);
    assign wr_status = IO_memWr_i && (word == OFF_UART_STATUS);
    assign wr_cycle  = IO_memWr_i && (word == OFF_CYCLE);

    assign full  = (count_q == DEPTH);
    assign empty = (count_q == '0);
    assign pop   = !empty && tx_ready;
    // A full FIFO still accepts a write when the transmitter pops in the same cycle.
    assign push  = wr_data && (!full || pop);

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
        leds_d   = wr_leds ? IO_memWData_i[7:0] : leds_q;
        cycle_d  = wr_cycle ? IO_memWData_i : cycle_q + 32'd1;
        ovf_d    = ovf_q;
        if (wr_status && IO_memWData_i[ST_OVERFLOW]) ovf_d = 1'b0;
        if (wr_data && !push)                       ovf_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            leds_q   <= 8'd0;
            cycle_q  <= 32'd0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            leds_q   <= leds_d;
            cycle_q  <= cycle_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_q] <= IO_memWData_i[7:0];
    end

    io_uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .data_valid_i(!empty),
        .data_i      (fifo_mem[rd_ptr_q]),
        .data_ready_o(tx_ready),
        .tx_o        (uart_tx_o),
        .busy_o      (tx_busy)
    );

    assign count_ext   = 32'(count_q);
    assign count_field = (count_ext > 32'd31) ? 5'd31 : count_ext[4:0];

    always_comb begin
        status = 32'd0;
        status[ST_BUSY]     = tx_busy;
        status[ST_FULL]     = full;
        status[ST_EMPTY]    = empty;
        status[ST_OVERFLOW] = ovf_q;
        status[ST_COUNT_LSB +: ST_COUNT_W] = count_field;
    end

    always_comb begin
        case (word)
            OFF_LEDS:        IO_memRData_o = {24'd0, leds_q};
            OFF_UART_STATUS: IO_memRData_o = status;
            OFF_CYCLE:       IO_memRData_o = cycle_q;
            default:         IO_memRData_o = 32'd0;
        endcase
    end

    assign leds_o = leds_q;

endmodule

// File: tb/tb_io_periph.sv
// Directed bench for io_periph with a short bit time and a 4-entry FIFO.
module tb_io_periph;
    import io_periph_pkg::*;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr  = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        wr    = 1'b0;
    logic [31:0] rdata;
    logic [7:0]  leds;
    logic        tx;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    io_periph #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk_i        (clk),
        .reset_i      (rst_n),
        .IO_memAddr_i (addr),
        .IO_memWData_i(wdata),
        .IO_memWr_i   (wr),
        .IO_memRData_o(rdata),
        .leds_o       (leds),
        .uart_tx_o    (tx)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input logic [3:0] w);
        return {26'd0, w, 2'b00};
    endfunction

    // One bus cycle: inputs change just after the falling edge, outputs settle by +1.
    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic w);
        @(negedge clk);
        addr  = a;
        wdata = d;
        wr    = w;
        if (w) $display("[TB] write addr=0x%08h data=0x%08h", a, d);
        #1;
    endtask

    // Expected line level k cycles after the start bit begins.
    function automatic logic exp_tx_bit(input logic [7:0] b, input int k);
        if (k < CPB)     return 1'b0;
        if (k < 9 * CPB) return b[(k - CPB) / CPB];
        return 1'b1;
    endfunction

    logic [7:0] cur_byte;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        addr = addr_of(OFF_UART_STATUS);
        #1;
        check("rst_leds", {24'd0, leds}, 32'd0);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_status", rdata, 32'h0000_0004);
        addr = addr_of(OFF_CYCLE);
        #1;
        check("rst_cycle", rdata, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("cycle_at_release", rdata, 32'd0);
        step(addr_of(OFF_CYCLE), 32'd0, 1'b0);
        check("cycle_first_inc", rdata, 32'd1);
        $display("[TB] reset released");

        // LEDS with junk in undecoded address bits; same-cycle read sees old value
        step(32'h1234_5603, 32'h0000_01FF, 1'b1);
        check("leds_same_cycle_old", rdata, 32'd0);
        step(addr_of(OFF_LEDS), 32'd0, 1'b0);
        check("leds_port", {24'd0, leds}, 32'h0000_00FF);
        check("leds_read", rdata, 32'h0000_00FF);

        // Unmapped offsets and write-only data register
        step(addr_of(4'd4), 32'h0000_005A, 1'b1);
        step(addr_of(4'd4), 32'd0, 1'b0);
        check("off4_read", rdata, 32'd0);
        check("off4_no_alias", {24'd0, leds}, 32'h0000_00FF);
        step(addr_of(4'd9), 32'd0, 1'b0);
        check("off9_read", rdata, 32'd0);
        step(addr_of(OFF_UART_DATA), 32'd0, 1'b0);
        check("uart_data_read", rdata, 32'd0);

        // CYCLE load and wrap
        step(addr_of(OFF_CYCLE), 32'hFFFF_FFFE, 1'b1);
        step(addr_of(OFF_CYCLE), 32'd0, 1'b0);
        check("cycle_load", rdata, 32'hFFFF_FFFE);
        step(addr_of(OFF_CYCLE), 32'd0, 1'b0);
        check("cycle_max", rdata, 32'hFFFF_FFFF);
        step(addr_of(OFF_CYCLE), 32'd0, 1'b0);
        check("cycle_wrap", rdata, 32'd0);

        // Single frame 0xA5
        step(addr_of(OFF_UART_DATA), 32'h0000_00A5, 1'b1);
        step(addr_of(OFF_UART_STATUS), 32'd0, 1'b0);
        check("a5_queued_status", rdata, 32'h0000_0100);
        check("a5_idle_line", {31'd0, tx}, 32'd1);
        for (int k = 0; k < 10 * CPB; k++) begin
            step(addr_of(OFF_UART_STATUS), 32'd0, 1'b0);
            check($sformatf("a5_tx[%0d]", k), {31'd0, tx}, {31'd0, exp_tx_bit(8'hA5, k)});
            check($sformatf("a5_busy[%0d]", k), {31'd0, rdata[0]}, 32'd1);
        end
        step(addr_of(OFF_UART_STATUS), 32'd0, 1'b0);
        check("a5_done_tx", {31'd0, tx}, 32'd1);
        check("a5_done_status", rdata, 32'h0000_0004);
        $display("[TB] frame 0xA5 done");

        // Six writes into a 4-deep FIFO, then five back-to-back frames
        for (int c = 0; c < 210; c++) begin
            if (c < 6) begin
                step(addr_of(OFF_UART_DATA), 32'h11 + 32'(c), 1'b1);
            end else if (c >= 7 && c < 21 && (c % 2) == 1) begin
                step(addr_of(4'd9), 32'd0, 1'b0);
            end else begin
                step(addr_of(OFF_UART_STATUS), 32'd0, 1'b0);
            end
            if (c >= 2 && c < 202) begin
                cur_byte = 8'h11 + 8'((c - 2) / 40);
                check($sformatf("burst_tx[%0d]", c), {31'd0, tx},
                      {31'd0, exp_tx_bit(cur_byte, (c - 2) % 40)});
            end else begin
                check($sformatf("burst_tx[%0d]", c), {31'd0, tx}, 32'd1);
            end
            if (c == 6) check("burst_status_ovf", rdata, 32'h0000_040B);
            if (c >= 7 && c < 21) begin
                if ((c % 2) == 1) check($sformatf("off9_busy[%0d]", c), rdata, 32'd0);
                else              check($sformatf("count_held[%0d]", c), rdata, 32'h0000_040B);
            end
        end
        check("burst_end_status", rdata, 32'h0000_000C);
        $display("[TB] burst of 5 frames done");

        step(addr_of(OFF_UART_STATUS), 32'h0000_0007, 1'b1);
        step(addr_of(OFF_UART_STATUS), 32'd0, 1'b0);
        check("ovf_kept_without_bit3", rdata, 32'h0000_000C);
        step(addr_of(OFF_UART_STATUS), 32'h0000_0008, 1'b1);
        step(addr_of(OFF_UART_STATUS), 32'd0, 1'b0);
        check("ovf_cleared", rdata, 32'h0000_0004);

        // Reset during data bit 3 of a frame with a second byte queued
        step(addr_of(OFF_UART_DATA), 32'h0000_0000, 1'b1);
        step(addr_of(OFF_UART_DATA), 32'h0000_0000, 1'b1);
        for (int c = 2; c < 20; c++) begin
            step(addr_of(OFF_UART_STATUS), 32'd0, 1'b0);
            check($sformatf("pre_rst_tx[%0d]", c), {31'd0, tx}, {31'd0, exp_tx_bit(8'h00, c - 2)});
        end
        rst_n = 1'b0;
        #1;
        check("rst_mid_frame_tx", {31'd0, tx}, 32'd1);
        check("rst_mid_frame_leds", {24'd0, leds}, 32'd0);
        check("rst_mid_frame_status", rdata, 32'h0000_0004);
        $display("[TB] reset asserted mid-frame");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 60; c++) begin
            step(addr_of(OFF_UART_STATUS), 32'd0, 1'b0);
            check($sformatf("post_rst_tx[%0d]", c), {31'd0, tx}, 32'd1);
        end
        check("post_rst_status", rdata, 32'h0000_0004);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
